// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: data width, the NOP
// bubble word and the fetch FSM state encoding.
package inst_fetch_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  // Fetch FSM state. Encoding 0 is deliberately unused, so a power-up
  // register value never looks like an active request.
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_FETCH = 2'd1;
  localparam fetch_state_t ST_SKID  = 2'd2;
  localparam fetch_state_t ST_DROP  = 2'd3;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {inst, pc} holding register. It catches a fetched word that
// arrives while the IF/ID buffer is stalled.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_load, i_inst, i_pc     capture an instruction and its PC
//   i_drain                  entry moved to IF/ID, mark empty
//   i_flush                  discard the entry (redirect); wins over load
//   o_valid, o_inst, o_pc    held entry
module fetch_skid_buffer
  import inst_fetch_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_drain,
  input  logic            i_flush,
  output logic            o_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc
);

  // Entry storage
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_inst  <= NOP;
      o_pc    <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_inst  <= i_inst;
      o_pc    <= i_pc;
    end else if (i_drain) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// RV32I instruction fetch stage. It owns the PC, issues word reads over a
// req/ack handshake, and fills the IF/ID buffer. It also handles redirects,
// decode stalls (through a one-entry skid) and drops reads made stale by a
// redirect.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When it is defined, a
// redirect to a non-word-aligned target delivers a NOP flagged on
// o_misaligned, and fetch idles until the next redirect.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   o_imemReq, o_imemAddr        memory read request (decoded from registers)
//   i_imemAck, i_imemRdata       one-cycle ack with instruction word
//   i_stall                      decode cannot accept
//   i_redirect, i_redirectPc     control-flow redirect and its target
//   o_valid, o_inst, o_pc        IF/ID buffer
//   o_pcPlus4                    o_pc + 4
//   o_misaligned                 (macro only) misaligned redirect target
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)
(
  input  logic            i_clk,
  input  logic            i_rst,
  output logic            o_imemReq,
  output logic [XLEN-1:0] o_imemAddr,
  input  logic            i_imemAck,
  input  logic [XLEN-1:0] i_imemRdata,
  input  logic            i_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirectPc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            o_misaligned,
`endif
  output logic            o_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pcPlus4
);

  fetch_state_t    r_state;
  fetch_state_t    w_stateNext;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_reqAddr;
  logic [XLEN-1:0] w_pcNext;
  logic            w_canAccept;
  logic            w_bufLoadMem;
  logic            w_bufLoadSkid;
  logic            w_skidLoad;
  logic            w_skidDrain;
  logic            w_misTgt;
  logic            w_misHold;
  logic            w_skidValid;
  logic [XLEN-1:0] w_skidInst;
  logic [XLEN-1:0] w_skidPc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misHold;

  // A misaligned redirect target parks fetch until the next redirect.
  assign w_misTgt  = i_redirect & (|i_redirectPc[1:0]);
  assign w_misHold = r_misHold;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_misHold <= 1'b0;
    end else if (i_redirect) begin
      r_misHold <= w_misTgt;
    end
  end

  // Flag travels with the buffer contents.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_misaligned <= 1'b0;
    end else if (i_redirect) begin
      o_misaligned <= w_misTgt;
    end else if (w_canAccept) begin
      o_misaligned <= 1'b0;
    end
  end
`else
  assign w_misTgt  = 1'b0;
  assign w_misHold = 1'b0;
`endif

  // DROP replays the stale address until its ack arrives. SKID issues nothing.
  assign o_imemReq  = (r_state == ST_FETCH) | (r_state == ST_DROP);
  assign o_imemAddr = (r_state == ST_DROP) ? r_reqAddr : r_pc;

  // Next-state and datapath control
  always_comb begin
    w_canAccept   = ~o_valid | ~i_stall;
    w_stateNext   = r_state;
    w_pcNext      = r_pc;
    w_bufLoadMem  = 1'b0;
    w_bufLoadSkid = 1'b0;
    w_skidLoad    = 1'b0;
    w_skidDrain   = 1'b0;

    case (r_state)
      ST_FETCH: begin
        if (i_imemAck) begin
          w_pcNext = r_pc + XLEN'(4);
          if (w_canAccept) begin
            w_bufLoadMem = 1'b1;
          end else begin
            w_skidLoad  = 1'b1;
            w_stateNext = ST_SKID;
          end
        end
      end
      ST_SKID: begin
        if (w_canAccept && !w_misHold) begin
          w_bufLoadSkid = w_skidValid;
          w_skidDrain   = 1'b1;
          w_stateNext   = ST_FETCH;
        end
      end
      ST_DROP: begin
        if (i_imemAck) begin
          w_stateNext = w_misHold ? ST_SKID : ST_FETCH;
        end
      end
      default: w_stateNext = ST_FETCH;
    endcase

    // Redirect overrides everything. A read still outstanding must be
    // absorbed in DROP so that its data never reaches decode.
    if (i_redirect) begin
      w_pcNext      = i_redirectPc;
      w_bufLoadMem  = 1'b0;
      w_bufLoadSkid = 1'b0;
      w_skidLoad    = 1'b0;
      w_skidDrain   = 1'b0;
      if ((r_state == ST_DROP) || ((r_state == ST_FETCH) && !i_imemAck)) begin
        w_stateNext = ST_DROP;
      end else begin
        w_stateNext = w_misTgt ? ST_SKID : ST_FETCH;
      end
    end
  end

  // State, PC and outstanding-request address
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_reqAddr <= RESET_PC;
    end else begin
      r_state <= w_stateNext;
      r_pc    <= w_pcNext;
      if (r_state == ST_FETCH) begin
        r_reqAddr <= r_pc;
      end
    end
  end

  // IF/ID buffer. It holds whenever decode stalls and nothing redirects.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid   <= 1'b0;
      o_inst    <= NOP;
      o_pc      <= '0;
      o_pcPlus4 <= XLEN'(4);
    end else if (i_redirect) begin
      o_valid <= w_misTgt;
      o_inst  <= NOP;
      if (w_misTgt) begin
        o_pc      <= i_redirectPc;
        o_pcPlus4 <= i_redirectPc + XLEN'(4);
      end
    end else if (w_bufLoadMem) begin
      o_valid   <= 1'b1;
      o_inst    <= i_imemRdata;
      o_pc      <= r_pc;
      o_pcPlus4 <= r_pc + XLEN'(4);
    end else if (w_bufLoadSkid) begin
      o_valid   <= 1'b1;
      o_inst    <= w_skidInst;
      o_pc      <= w_skidPc;
      o_pcPlus4 <= w_skidPc + XLEN'(4);
    end else if (w_canAccept) begin
      o_valid <= 1'b0;
      o_inst  <= NOP;
    end
  end

  fetch_skid_buffer u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_skidLoad),
    .i_inst  (i_imemRdata),
    .i_pc    (r_pc),
    .i_drain (w_skidDrain),
    .i_flush (i_redirect),
    .o_valid (w_skidValid),
    .o_inst  (w_skidInst),
    .o_pc    (w_skidPc)
  );

endmodule
